// File: rtl/hello_scroll_sequencer.sv
// hello_scroll_sequencer: paces and sequences the 8-digit HELLO marquee.
// A prescaled step tick drives IDLE -> FILL (8 loads) -> ROTATE (endless shifts).
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   run_i          1 = prescaler advances, 0 = pause (everything holds)
//   restart_i      synchronous return to IDLE, clears the prescaler
//   dir_i          rotate direction request (0 = left, 1 = right)
//   load_o         one-cycle pulse, shift register captures char_code_o
//   char_code_o    blank=0 H=1 E=2 L=3 O=4, zero when load_o=0
//   shift_o        one-cycle pulse, shift register rotates one digit
//   shift_dir_o    direction of this shift, zero when shift_o=0
//   phase_o        IDLE=0 FILL=1 ROTATE=2
//   index_o        FILL position of the next character, zero outside FILL
module hello_scroll_sequencer #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       run_i,
    input  logic       restart_i,
    input  logic       dir_i,
    output logic       load_o,
    output logic [2:0] char_code_o,
    output logic       shift_o,
    output logic       shift_dir_o,
    output logic [1:0] phase_o,
    output logic [2:0] index_o
);

    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_FILL   = 2'd1,
        PH_ROTATE = 2'd2,
        PH_BAD    = 2'd3
    } phase_e;

    localparam int unsigned     CW       = 26;
    localparam logic [CW-1:0]   CNT_LAST = CW'(TICK_DIV - 1);

    // Character codes of the message, in load order.
    localparam logic [2:0] C_BLANK = 3'd0;
    localparam logic [2:0] C_H     = 3'd1;
    localparam logic [2:0] C_E     = 3'd2;
    localparam logic [2:0] C_L     = 3'd3;
    localparam logic [2:0] C_O     = 3'd4;

    logic [CW-1:0] cnt_q, cnt_d;
    phase_e        phase_q, phase_d;
    logic [2:0]    index_q, index_d;
    logic          load_q, load_d;
    logic [2:0]    code_q, code_d;
    logic          shift_q, shift_d;
    logic          sdir_q, sdir_d;

    logic tick;
    logic illegal;

    function automatic logic [2:0] msg_char(input logic [2:0] idx);
        logic [2:0] c;
        case (idx)
            3'd0:    c = C_H;
            3'd1:    c = C_E;
            3'd2:    c = C_L;
            3'd3:    c = C_L;
            3'd4:    c = C_O;
            default: c = C_BLANK;
        endcase
        return c;
    endfunction

    assign tick = run_i && (cnt_q == CNT_LAST);

    // Index is only meaningful in FILL; anything else non-zero is corrupt.
    assign illegal = (phase_q == PH_BAD) ||
                     ((phase_q != PH_FILL) && (index_q != 3'd0));

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        index_d = index_q;
        load_d  = 1'b0;
        code_d  = 3'd0;
        shift_d = 1'b0;
        sdir_d  = 1'b0;

        if (restart_i || illegal) begin
            // Restart wins over a coincident tick; corrupt state self-heals.
            cnt_d   = '0;
            phase_d = PH_IDLE;
            index_d = 3'd0;
        end else if (run_i) begin
            if (tick) begin
                cnt_d = '0;
                case (phase_q)
                    PH_IDLE: begin
                        phase_d = PH_FILL;
                        index_d = 3'd0;
                    end
                    PH_FILL: begin
                        load_d = 1'b1;
                        code_d = msg_char(index_q);
                        if (index_q == 3'd7) begin
                            phase_d = PH_ROTATE;
                            index_d = 3'd0;
                        end else begin
                            index_d = index_q + 3'd1;
                        end
                    end
                    PH_ROTATE: begin
                        shift_d = 1'b1;
                        sdir_d  = dir_i;
                    end
                    default: begin
                        phase_d = PH_IDLE;
                        index_d = 3'd0;
                    end
                endcase
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            phase_q <= PH_IDLE;
            index_q <= 3'd0;
            load_q  <= 1'b0;
            code_q  <= 3'd0;
            shift_q <= 1'b0;
            sdir_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            index_q <= index_d;
            load_q  <= load_d;
            code_q  <= code_d;
            shift_q <= shift_d;
            sdir_q  <= sdir_d;
        end
    end

    assign load_o      = load_q;
    assign char_code_o = code_q;
    assign shift_o     = shift_q;
    assign shift_dir_o = sdir_q;
    assign phase_o     = phase_q;
    assign index_o     = index_q;

endmodule

// File: tb/tb_hello_scroll_sequencer.sv
// Bench for hello_scroll_sequencer: scenario table driven per edge,
// expected outputs queued at drive time and compared after each edge.
module tb_hello_scroll_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic run = 1'b0;
    logic restart = 1'b0;
    logic dir = 1'b0;

    always #5 clk = ~clk;

    logic       l4, s4, d4;
    logic [2:0] c4, i4;
    logic [1:0] p4;
    logic       l1, s1, d1;
    logic [2:0] c1, i1;
    logic [1:0] p1;

    hello_scroll_sequencer #(.TICK_DIV(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .run_i(run), .restart_i(restart),
        .dir_i(dir), .load_o(l4), .char_code_o(c4), .shift_o(s4),
        .shift_dir_o(d4), .phase_o(p4), .index_o(i4)
    );

    hello_scroll_sequencer #(.TICK_DIV(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .run_i(run), .restart_i(restart),
        .dir_i(dir), .load_o(l1), .char_code_o(c1), .shift_o(s1),
        .shift_dir_o(d1), .phase_o(p1), .index_o(i1)
    );

    typedef struct {
        int         sel;
        int         edges;
        int         pause_at;
        int         pause_len;
        int         restart_at;
        int         dir_from;
        int         exp_loads;
        int         exp_shifts;
        logic [1:0] exp_phase;
    } scen_t;

    typedef struct {
        logic       load;
        logic [2:0] code;
        logic       shift;
        logic       sdir;
        logic [1:0] phase;
        logic [2:0] idx;
    } obs_t;

    obs_t       sb[$];
    scen_t      scen[4];
    logic [2:0] msg[8];
    int         total = 0;
    int         bad = 0;

    task automatic cmp(input string name, input int e, input int act,
                       input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s edge=%0d got=%0d want=%0d", name, e, act, want);
        end
    endtask

    task automatic get_act(input int sel, output obs_t a);
        if (sel == 0) begin
            a.load = l4; a.code = c4; a.shift = s4;
            a.sdir = d4; a.phase = p4; a.idx = i4;
        end else begin
            a.load = l1; a.code = c1; a.shift = s1;
            a.sdir = d1; a.phase = p1; a.idx = i1;
        end
    endtask

    task automatic cmp_obs(input string tag, input int e, input obs_t a,
                           input obs_t x);
        cmp({tag, ".load"}, e, a.load, x.load);
        cmp({tag, ".code"}, e, a.code, x.code);
        cmp({tag, ".shift"}, e, a.shift, x.shift);
        cmp({tag, ".sdir"}, e, a.sdir, x.sdir);
        cmp({tag, ".phase"}, e, a.phase, x.phase);
        cmp({tag, ".index"}, e, a.idx, x.idx);
        cmp({tag, ".load_and_shift"}, e, a.load & a.shift, 0);
    endtask

    // Asserted between edges; outputs must clear without a clock edge.
    task automatic do_reset(input int sel);
        obs_t a;
        obs_t z;
        z = '{default: '0};
        rst_n = 1'b0;
        restart = 1'b0;
        #1;
        get_act(sel, a);
        cmp_obs("reset", 0, a, z);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic run_scen(input scen_t s);
        int   a_cnt;
        int   t;
        int   n;
        int   loads;
        int   shifts;
        bit   tick;
        obs_t x;
        obs_t a;
        a_cnt = 0;
        loads = 0;
        shifts = 0;
        t = (s.sel == 0) ? 4 : 1;
        for (int e = 1; e <= s.edges; e++) begin
            run = !((e > s.pause_at) && (e <= s.pause_at + s.pause_len));
            restart = (e == s.restart_at);
            dir = (e >= s.dir_from);
            tick = 1'b0;
            if (restart) begin
                a_cnt = 0;
            end else if (run) begin
                a_cnt++;
                tick = ((a_cnt % t) == 0);
            end
            n = a_cnt / t;
            x.phase = (n == 0) ? 2'd0 : ((n <= 8) ? 2'd1 : 2'd2);
            x.idx = (n >= 1 && n <= 8) ? 3'(n - 1) : 3'd0;
            x.load = tick && (n >= 2) && (n <= 9);
            x.code = x.load ? msg[n - 2] : 3'd0;
            x.shift = tick && (n >= 10);
            x.sdir = x.shift ? dir : 1'b0;
            sb.push_back(x);
            @(posedge clk);
            #1;
            x = sb.pop_front();
            get_act(s.sel, a);
            cmp_obs("step", e, a, x);
            if (a.load) loads++;
            if (a.shift) shifts++;
        end
        restart = 1'b0;
        cmp("scen.loads", s.edges, loads, s.exp_loads);
        cmp("scen.shifts", s.edges, shifts, s.exp_shifts);
        get_act(s.sel, a);
        cmp("scen.phase", s.edges, a.phase, s.exp_phase);
    endtask

    initial begin
        obs_t a;
        msg = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd4, 3'd0, 3'd0, 3'd0};
        // sel edges pause_at pause_len restart_at dir_from loads shifts phase
        scen[0] = '{0, 48, 0, 0, 0, 45, 8, 3, 2'd2};
        scen[1] = '{0, 58, 16, 10, 0, 1000, 8, 3, 2'd2};
        scen[2] = '{0, 56, 0, 0, 16, 1000, 10, 1, 2'd2};
        scen[3] = '{1, 14, 0, 0, 0, 12, 8, 5, 2'd2};

        #1;
        for (int k = 0; k < 4; k++) begin
            do_reset(scen[k].sel);
            run_scen(scen[k]);
        end

        // Mid-ROTATE reset right after a shift pulse: pulse is truncated.
        do_reset(0);
        run_scen(scen[0]);
        get_act(0, a);
        cmp("pre_reset.shift", 48, a.shift, 1);
        do_reset(0);
        run_scen(scen[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
